// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, response and memory/CSR signals shared by mem_port_arbiter and its environment.
// The arbiter side uses the slave modport; requesters and memory models use master.
interface mem_port_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]    IN_req_valid;
   logic [NUM_REQ-1:0]    IN_req_we;
   logic [NUM_REQ*30-1:0] IN_req_addr;
   logic [NUM_REQ*32-1:0] IN_req_data;
   logic [NUM_REQ*4-1:0]  IN_req_wm;
   logic [NUM_REQ-1:0]    OUT_req_ready;
   logic [NUM_REQ-1:0]    IN_rsp_kill;
   logic [NUM_REQ-1:0]    OUT_rsp_valid;
   logic [31:0]           OUT_rsp_data;
   logic [29:0]           OUT_MEM_addr;
   logic [31:0]           OUT_MEM_data;
   logic                  OUT_MEM_we;
   logic                  OUT_MEM_ce;
   logic [3:0]            OUT_MEM_wm;
   logic                  OUT_CSR_ce;
   logic [31:0]           IN_MEM_data;
   logic [31:0]           IN_CSR_data;
   logic                  IN_IO_busy;

   modport slave (
      input  IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm,
      input  IN_rsp_kill, IN_MEM_data, IN_CSR_data, IN_IO_busy,
      output OUT_req_ready, OUT_rsp_valid, OUT_rsp_data,
      output OUT_MEM_addr, OUT_MEM_data, OUT_MEM_we, OUT_MEM_ce, OUT_MEM_wm, OUT_CSR_ce
   );

   modport master (
      output IN_req_valid, IN_req_we, IN_req_addr, IN_req_data, IN_req_wm,
      output IN_rsp_kill, IN_MEM_data, IN_CSR_data, IN_IO_busy,
      input  OUT_req_ready, OUT_rsp_valid, OUT_rsp_data,
      input  OUT_MEM_addr, OUT_MEM_data, OUT_MEM_we, OUT_MEM_ce, OUT_MEM_wm, OUT_CSR_ce
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fixed-priority SRAM/CSR port arbiter with anti-starvation promotion and MMIO ordering gates.
// Define MEMARB_PERF_EN to add the conflict and forced-promotion performance counters.
module mem_port_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int STARVE_LIMIT = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.slave    bus
`ifdef MEMARB_PERF_EN
   ,
   output logic [31:0]          OUT_perf_conflicts,
   output logic [31:0]          OUT_perf_starve
`endif
);

   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

   logic [AGE_W-1:0]   age [1:NUM_REQ-1];
   logic [NUM_REQ-1:0] is_io;
   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] starve;
   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic               sel_we;
   logic               sel_io;
   logic [29:0]        sel_addr;
   logic [31:0]        sel_data;
   logic [3:0]         sel_wm;
   logic [NUM_REQ-1:0] rsp_sel;
   logic               rsp_io;
   logic               io_hold;

   always_comb begin
      is_io  = '0;
      elig   = '0;
      starve = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         is_io[k] = (bus.IN_req_addr[30*k+22 +: 8] == 8'hff);
         elig[k]  = bus.IN_req_valid[k] & ~(is_io[k] & (bus.IN_IO_busy | io_hold));
      end
      for (int k = 1; k < NUM_REQ; k++)
         starve[k] = elig[k] && (age[k] == AGE_MAX);
   end

   // Descending loops let the lowest index overwrite higher ones.
   always_comb begin
      grant = '0;
      if (rst) begin
         if (|starve) begin
            for (int k = NUM_REQ - 1; k >= 0; k--)
               if (starve[k]) begin
                  grant    = '0;
                  grant[k] = 1'b1;
               end
         end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--)
               if (elig[k]) begin
                  grant    = '0;
                  grant[k] = 1'b1;
               end
         end
      end
   end

   always_comb begin
      sel_we   = 1'b0;
      sel_io   = 1'b0;
      sel_addr = '0;
      sel_data = '0;
      sel_wm   = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (grant[k]) begin
            sel_we   = bus.IN_req_we[k];
            sel_io   = is_io[k];
            sel_addr = bus.IN_req_addr[30*k +: 30];
            sel_data = bus.IN_req_data[32*k +: 32];
            sel_wm   = bus.IN_req_wm[4*k +: 4];
         end
   end

   assign any_grant         = |grant;
   assign bus.OUT_req_ready = grant;
   assign bus.OUT_MEM_addr  = sel_addr;
   assign bus.OUT_MEM_data  = sel_data;
   assign bus.OUT_MEM_wm    = sel_wm;
   assign bus.OUT_MEM_we    = ~(any_grant & sel_we);
   assign bus.OUT_MEM_ce    = ~(any_grant & ~sel_io);
   assign bus.OUT_CSR_ce    = ~(any_grant & sel_io);

   // IO-gated requesters hold their age so the gate cannot be used to jump the queue.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 1; k < NUM_REQ; k++)
            age[k] <= '0;
      end else begin
         for (int k = 1; k < NUM_REQ; k++) begin
            if (grant[k] || !bus.IN_req_valid[k])
               age[k] <= '0;
            else if (elig[k] && (age[k] != AGE_MAX))
               age[k] <= age[k] + AGE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_sel <= '0;
         rsp_io  <= 1'b0;
         io_hold <= 1'b0;
      end else begin
         rsp_sel <= (any_grant && !sel_we) ? grant : '0;
         rsp_io  <= any_grant & ~sel_we & sel_io;
         io_hold <= any_grant & sel_we & sel_io;
      end
   end

   assign bus.OUT_rsp_valid = rsp_sel & ~bus.IN_rsp_kill;
   assign bus.OUT_rsp_data  = rsp_io ? bus.IN_CSR_data : bus.IN_MEM_data;

`ifdef MEMARB_PERF_EN
   logic        forced;
   logic [31:0] conflicts_cnt;
   logic [31:0] starve_cnt;

   assign forced = rst & (|starve);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         conflicts_cnt <= '0;
         starve_cnt    <= '0;
      end else begin
         if ($countones(bus.IN_req_valid) > 1)
            conflicts_cnt <= conflicts_cnt + 32'd1;
         if (forced)
            starve_cnt <= starve_cnt + 32'd1;
      end
   end

   assign OUT_perf_conflicts = conflicts_cnt;
   assign OUT_perf_starve    = starve_cnt;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, priority, starvation, MMIO gating, kill and reset-abort.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   mem_port_arbiter_if #(.NUM_REQ(3)) bus ();

`ifdef MEMARB_PERF_EN
   logic [31:0] perf_conflicts;
   logic [31:0] perf_starve;
   mem_port_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(7)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .OUT_perf_conflicts(perf_conflicts), .OUT_perf_starve(perf_starve)
   );
`else
   mem_port_arbiter #(.NUM_REQ(3), .STARVE_LIMIT(7)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
`endif

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_req(input int k, input logic v, input logic we,
                          input logic [29:0] a, input logic [31:0] d, input logic [3:0] wm);
      bus.IN_req_valid[k]          = v;
      bus.IN_req_we[k]             = we;
      bus.IN_req_addr[30*k +: 30]  = a;
      bus.IN_req_data[32*k +: 32]  = d;
      bus.IN_req_wm[4*k +: 4]      = wm;
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst = 1'b0;
      bus.IN_rsp_kill = '0;
      bus.IN_MEM_data = 32'h0;
      bus.IN_CSR_data = 32'h0;
      bus.IN_IO_busy  = 1'b0;
      set_req(0, 1'b1, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b1, 1'b0, 30'h200, 32'h0, 4'h0);
      set_req(2, 1'b1, 1'b0, 30'h300, 32'h0, 4'h0);

      // Reset with everybody requesting
      #2;
      chk("rst_ready", bus.OUT_req_ready, 3'b000);
      chk("rst_mem_ce", bus.OUT_MEM_ce, 1'b1);
      chk("rst_csr_ce", bus.OUT_CSR_ce, 1'b1);
      chk("rst_mem_we", bus.OUT_MEM_we, 1'b1);
      chk("rst_mem_addr", bus.OUT_MEM_addr, 30'h0);
      chk("rst_rsp_valid", bus.OUT_rsp_valid, 3'b000);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("release_ready", bus.OUT_req_ready, 3'b001);
      chk("release_addr", bus.OUT_MEM_addr, 30'h100);

      // Priority: req0 beats req1, response the next cycle
      @(negedge clk);
      set_req(2, 1'b0, 1'b0, 30'h300, 32'h0, 4'h0);
      bus.IN_MEM_data = 32'hdeadbeef;
      #1;
      chk("prio_ready", bus.OUT_req_ready, 3'b001);
      chk("prio_addr", bus.OUT_MEM_addr, 30'h100);
      chk("prio_we", bus.OUT_MEM_we, 1'b1);
      chk("prio_ce", bus.OUT_MEM_ce, 1'b0);
      chk("prio_prev_rsp", bus.OUT_rsp_valid, 3'b001);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 30'h200, 32'h0, 4'h0);
      bus.IN_MEM_data = 32'h12345678;
      #1;
      chk("prio_rsp_valid", bus.OUT_rsp_valid, 3'b001);
      chk("prio_rsp_data", bus.OUT_rsp_data, 32'h12345678);
      chk("idle_ready", bus.OUT_req_ready, 3'b000);
      chk("idle_mem_ce", bus.OUT_MEM_ce, 1'b1);
      chk("idle_csr_ce", bus.OUT_CSR_ce, 1'b1);

      // Starvation: req1 promoted on the eighth contended cycle
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b1, 1'b0, 30'h200, 32'h0, 4'h0);
      for (int i = 0; i < 7; i++) begin
         #1;
         chk("starve_wait", bus.OUT_req_ready, 3'b001);
         @(negedge clk);
      end
      #1;
      chk("starve_promote", bus.OUT_req_ready, 3'b010);
      chk("starve_addr", bus.OUT_MEM_addr, 30'h200);
      @(negedge clk);
      #1;
      chk("starve_age_clear", bus.OUT_req_ready, 3'b001);
      chk("starve_rsp", bus.OUT_rsp_valid, 3'b010);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 30'h200, 32'h0, 4'h0);

      // MMIO: IO write, then the following IO read is held off one cycle
      @(negedge clk);
      set_req(1, 1'b1, 1'b1, 30'h3fc00000, 32'hcafe0001, 4'b0101);
      #1;
      chk("io_wr_ready", bus.OUT_req_ready, 3'b010);
      chk("io_wr_csr_ce", bus.OUT_CSR_ce, 1'b0);
      chk("io_wr_mem_ce", bus.OUT_MEM_ce, 1'b1);
      chk("io_wr_we", bus.OUT_MEM_we, 1'b0);
      chk("io_wr_addr", bus.OUT_MEM_addr, 30'h3fc00000);
      chk("io_wr_data", bus.OUT_MEM_data, 32'hcafe0001);
      chk("io_wr_wm", bus.OUT_MEM_wm, 4'b0101);
      @(negedge clk);
      set_req(1, 1'b1, 1'b0, 30'h3fc00004, 32'h0, 4'h0);
      #1;
      chk("io_hold_ready", bus.OUT_req_ready, 3'b000);
      chk("io_hold_csr_ce", bus.OUT_CSR_ce, 1'b1);
      chk("io_wr_no_rsp", bus.OUT_rsp_valid, 3'b000);
      @(negedge clk);
      #1;
      chk("io_rd_ready", bus.OUT_req_ready, 3'b010);
      chk("io_rd_csr_ce", bus.OUT_CSR_ce, 1'b0);
      chk("io_rd_we", bus.OUT_MEM_we, 1'b1);
      @(negedge clk);
      set_req(1, 1'b0, 1'b0, 30'h3fc00004, 32'h0, 4'h0);
      bus.IN_CSR_data = 32'h000000ab;
      bus.IN_MEM_data = 32'h55555555;
      #1;
      chk("io_rsp_valid", bus.OUT_rsp_valid, 3'b010);
      chk("io_rsp_data", bus.OUT_rsp_data, 32'h000000ab);

      // IO busy: age[1] builds to 3, holds while gated, then 4 more cycles to promotion
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b1, 1'b0, 30'h200, 32'h0, 4'h0);
      repeat (3) @(negedge clk);
      set_req(1, 1'b1, 1'b0, 30'h3fc00010, 32'h0, 4'h0);
      bus.IN_IO_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("busy_blocked", bus.OUT_req_ready, 3'b001);
         @(negedge clk);
      end
      bus.IN_IO_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("busy_age_held", bus.OUT_req_ready, 3'b001);
         @(negedge clk);
      end
      #1;
      chk("busy_promote", bus.OUT_req_ready, 3'b010);
      chk("busy_promote_csr", bus.OUT_CSR_ce, 1'b0);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 30'h200, 32'h0, 4'h0);

      // Kill: squashed read response, concurrent req2 write unaffected
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 30'h040, 32'h0, 4'h0);
      #1;
      chk("kill_rd_ready", bus.OUT_req_ready, 3'b001);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h040, 32'h0, 4'h0);
      set_req(2, 1'b1, 1'b1, 30'h080, 32'h00000055, 4'hf);
      bus.IN_rsp_kill = 3'b001;
      #1;
      chk("kill_rsp_valid", bus.OUT_rsp_valid, 3'b000);
      chk("kill_wr_ready", bus.OUT_req_ready, 3'b100);
      chk("kill_wr_we", bus.OUT_MEM_we, 1'b0);
      chk("kill_wr_ce", bus.OUT_MEM_ce, 1'b0);
      chk("kill_wr_addr", bus.OUT_MEM_addr, 30'h080);
      @(negedge clk);
      set_req(2, 1'b0, 1'b0, 30'h080, 32'h0, 4'h0);
      bus.IN_rsp_kill = 3'b000;
      #1;
      chk("kill_wr_no_rsp", bus.OUT_rsp_valid, 3'b000);

      // Back-to-back reads
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 30'h010, 32'h0, 4'h0);
      @(negedge clk);
      #1;
      chk("b2b_rsp1", bus.OUT_rsp_valid, 3'b001);
      chk("b2b_ready2", bus.OUT_req_ready, 3'b001);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h010, 32'h0, 4'h0);
      #1;
      chk("b2b_rsp2", bus.OUT_rsp_valid, 3'b001);

      // Reset while a response is pending discards it
      @(negedge clk);
      set_req(0, 1'b1, 1'b0, 30'h020, 32'h0, 4'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort_rsp_valid", bus.OUT_rsp_valid, 3'b000);
      chk("abort_ready", bus.OUT_req_ready, 3'b000);
      chk("abort_mem_ce", bus.OUT_MEM_ce, 1'b1);
      @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h020, 32'h0, 4'h0);
      rst = 1'b1;
      #1;
      chk("abort_no_replay", bus.OUT_rsp_valid, 3'b000);

`ifdef MEMARB_PERF_EN
      // Performance counters over 10 fully contended cycles
      @(negedge clk);
      rst = 1'b0;
      #1;
      rst = 1'b1;
      chk("perf_reset", perf_conflicts, 32'd0);
      set_req(0, 1'b1, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b1, 1'b0, 30'h200, 32'h0, 4'h0);
      set_req(2, 1'b1, 1'b0, 30'h300, 32'h0, 4'h0);
      repeat (7) @(negedge clk);
      #1;
      chk("perf_force1", bus.OUT_req_ready, 3'b010);
      @(negedge clk);
      #1;
      chk("perf_force2", bus.OUT_req_ready, 3'b100);
      repeat (2) @(negedge clk);
      set_req(0, 1'b0, 1'b0, 30'h100, 32'h0, 4'h0);
      set_req(1, 1'b0, 1'b0, 30'h200, 32'h0, 4'h0);
      set_req(2, 1'b0, 1'b0, 30'h300, 32'h0, 4'h0);
      #1;
      chk("perf_conflicts", perf_conflicts, 32'd10);
      chk("perf_starve", perf_starve, 32'd2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
